// File: rtl/tiner.sv
// Level-enabled one-shot delay timer: ti rises TICKS ticks after en is sampled high.
// Optional tick prescaler is built only when TINER_PRESCALE_EN is defined.
module tiner #(
    parameter int WIDTH    = 8,
    parameter int TICKS    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             ti,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TICKS - 1);

    if ((TICKS < 1) || (TICKS >= (2 ** WIDTH))) begin : g_bad_ticks
        $error("tiner: TICKS=%0d out of range 1..%0d", TICKS, (2 ** WIDTH) - 1);
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("tiner: PRESCALE=%0d must be >= 1", PRESCALE);
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_s;

`ifdef TINER_PRESCALE_EN
    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick_s = (presc_q == PRESC_LAST);

    // Prescaler runs only while counting; held at zero everywhere else so RUN entry starts fresh.
    always_comb begin
        presc_d = presc_q;
        if (en && (state_q == ST_RUN)) begin
            if (tick_s) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_d = {PW{1'b0}};
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= {PW{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // Next-state and tick counter; en low from any state is the restart path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = {WIDTH{1'b0}};
                end
                ST_RUN: begin
                    if (tick_s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                    cnt_d   = cnt_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ti is gated by the live en so it drops in the same cycle as the request.
    assign ti    = (state_q == ST_DONE) & en;
    assign busy  = (state_q == ST_RUN);
    assign count = cnt_q;

endmodule

// File: tb/tb_tiner.sv
// Directed scoreboard bench for tiner; expected outputs are queued per step and checked after each edge.
module tb_tiner;

`ifdef TINER_PRESCALE_EN
    localparam int TICKS_C = 4;
    localparam int P_C     = 3;
`else
    localparam int TICKS_C = 10;
    localparam int P_C     = 1;
`endif
    localparam int N_C = TICKS_C * P_C;

    typedef struct {
        logic       ti;
        logic       busy;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       ti;
    logic       busy;
    logic [7:0] count;

    exp_t exp_q[$];
    int   n_assert;
    int   n_fail;

    tiner #(.WIDTH(8), .TICKS(TICKS_C), .PRESCALE(P_C)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .ti    (ti),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic xti, input logic xbusy, input int xcnt, input string tag);
        exp_t e;
        e.ti   = xti;
        e.busy = xbusy;
        e.cnt  = 8'(xcnt);
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = exp_q.pop_front();
        n_assert++;
        assert (ti === e.ti) else begin
            n_fail++;
            $error("FAIL %s.ti: observed=%b expected=%b", e.tag, ti, e.ti);
        end
        n_assert++;
        assert (busy === e.busy) else begin
            n_fail++;
            $error("FAIL %s.busy: observed=%b expected=%b", e.tag, busy, e.busy);
        end
        n_assert++;
        assert (count === e.cnt) else begin
            n_fail++;
            $error("FAIL %s.count: observed=%0d expected=%0d", e.tag, count, e.cnt);
        end
    endtask

    // Drive en, advance one edge, then check.
    task automatic cycle(input logic e, input logic xti, input logic xbusy, input int xcnt, input string tag);
        en = e;
        push_exp(xti, xbusy, xcnt, tag);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // Drive en and check without any clock edge.
    task automatic check_now(input logic e, input logic xti, input logic xbusy, input int xcnt, input string tag);
        en = e;
        push_exp(xti, xbusy, xcnt, tag);
        #1;
        compare_front();
    endtask

    initial begin
        int m;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b1;

        // reset asserted with en=1, before any clock edge
        #3;
        check_now(1'b1, 1'b0, 1'b0, 0, "rst_async");
        cycle(1'b1, 1'b0, 1'b0, 0, "rst_hold");
        en = 1'b0;
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 0, "idle");

        // full delay
        for (int i = 0; i < N_C; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i / P_C, "run");
        end
        cycle(1'b1, 1'b1, 1'b0, TICKS_C - 1, "done");
        cycle(1'b1, 1'b1, 1'b0, TICKS_C - 1, "done_hold1");
        cycle(1'b1, 1'b1, 1'b0, TICKS_C - 1, "done_hold2");

        // drop en in DONE: ti falls combinationally, next edge idles
        check_now(1'b0, 1'b0, 1'b0, TICKS_C - 1, "drop_comb");
        cycle(1'b0, 1'b0, 1'b0, 0, "drop_idle");

        // short pulse never reaches ti
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i / P_C, "short");
        end
        cycle(1'b0, 1'b0, 1'b0, 0, "short_clr");
        cycle(1'b0, 1'b0, 1'b0, 0, "short_idle");

        // restart gives the full delay again
        for (int i = 0; i < N_C; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i / P_C, "rerun");
        end
        cycle(1'b1, 1'b1, 1'b0, TICKS_C - 1, "redone");
        cycle(1'b0, 1'b0, 1'b0, 0, "redone_clr");

        // reset mid-run (count=6 with defaults)
        m = (TICKS_C > 6) ? (6 * P_C + 1) : (N_C / 2);
        for (int i = 0; i < m; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i / P_C, "pre_rst");
        end
        #3;
        reset = 1'b1;
        check_now(1'b1, 1'b0, 1'b0, 0, "rst_mid");
        cycle(1'b1, 1'b0, 1'b0, 0, "rst_mid_hold");
        reset = 1'b0;
        for (int i = 0; i < N_C; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i / P_C, "post_rst");
        end
        cycle(1'b1, 1'b1, 1'b0, TICKS_C - 1, "post_rst_done");
        cycle(1'b0, 1'b0, 1'b0, 0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
